// File: rtl/mm_bus_pkg.sv
// Shared types and constants for the two-master memory-mapped bus arbiter.
package mm_bus_pkg;

    localparam int unsigned MM_ADDR_W      = 17;
    localparam int unsigned MM_DATA_W      = 64;
    localparam logic [31:0] MM_TIMEOUT_TAG = 32'hDEAD_0BAD;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RD_WAIT,
        DONE
    } mm_arb_state_e;

endpackage

// File: rtl/mm_rr_arb2.sv
// Two-requester round-robin picker: combinational grant, registered last-grant pointer.
module mm_rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic       update_i,
    output logic       gnt_o,
    output logic       valid_o
);

    logic last_q;
    logic last_d;

    always_comb begin
        valid_o = |req_i;
        // On contention the requester not granted last wins; otherwise the sole requester.
        if (&req_i) begin
            gnt_o = ~last_q;
        end else begin
            gnt_o = req_i[1];
        end
        last_d = last_q;
        if (update_i && valid_o) begin
            last_d = gnt_o;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/mm_bus_arbiter.sv
// Two-master arbiter/sequencer for the register bus with one transaction in flight
// and read-timeout error completion.
module mm_bus_arbiter
    import mm_bus_pkg::*;
#(
    parameter int unsigned ADDR_W      = MM_ADDR_W,
    parameter int unsigned DATA_W      = MM_DATA_W,
    parameter int unsigned TIMEOUT_CYC = 256,
    parameter int unsigned CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              iM0_WR_EN,
    input  logic              iM1_WR_EN,
    input  logic              iM0_RD_EN,
    input  logic              iM1_RD_EN,
    input  logic [ADDR_W-1:0] iM0_ADDR,
    input  logic [ADDR_W-1:0] iM1_ADDR,
    input  logic [DATA_W-1:0] iM0_WR_DATA,
    input  logic [DATA_W-1:0] iM1_WR_DATA,
    output logic              oM0_ACK,
    output logic              oM1_ACK,
    output logic [DATA_W-1:0] oM0_RD_DATA,
    output logic [DATA_W-1:0] oM1_RD_DATA,
    output logic              oM0_RD_DATA_V,
    output logic              oM1_RD_DATA_V,
    output logic              oM0_ERR,
    output logic              oM1_ERR,
    output logic              oMM_WR_EN,
    output logic              oMM_RD_EN,
    output logic [ADDR_W-1:0] oMM_ADDR,
    output logic [DATA_W-1:0] oMM_WR_DATA,
    input  logic [DATA_W-1:0] iMM_RD_DATA,
    input  logic              iMM_RD_DATA_V,
    input  logic              iTIMEOUT_CLR,
    output logic [CNT_W-1:0]  oTIMEOUT_CNT
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC);
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT_CYC - 1);

    mm_arb_state_e     state_q, state_d;
    logic              gnt_q, gnt_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              mm_wr_en_q, mm_wr_en_d;
    logic              mm_rd_en_q, mm_rd_en_d;
    logic [ADDR_W-1:0] mm_addr_q, mm_addr_d;
    logic [DATA_W-1:0] mm_wr_data_q, mm_wr_data_d;
    logic [1:0]        ack_q, ack_d;
    logic [1:0]        rd_v_q, rd_v_d;
    logic [1:0]        err_q, err_d;
    logic [DATA_W-1:0] rd_data_q [2];
    logic [DATA_W-1:0] rd_data_d [2];
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [1:0]        m_req;
    logic [1:0]        m_wr;
    logic [ADDR_W-1:0] m_addr [2];
    logic [DATA_W-1:0] m_data [2];
    logic              arb_gnt;
    logic              arb_valid;
    logic              arb_update;
    logic [DATA_W-1:0] tmo_data;

    always_comb begin
        m_wr      = {iM1_WR_EN, iM0_WR_EN};
        m_req     = m_wr | {iM1_RD_EN, iM0_RD_EN};
        m_addr[0] = iM0_ADDR;
        m_addr[1] = iM1_ADDR;
        m_data[0] = iM0_WR_DATA;
        m_data[1] = iM1_WR_DATA;
        tmo_data  = '0;
        tmo_data[ADDR_W-1:0]   = mm_addr_q;
        tmo_data[DATA_W-1-:32] = MM_TIMEOUT_TAG;
    end

    mm_rr_arb2 u_rr (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .req_i    (m_req),
        .update_i (arb_update),
        .gnt_o    (arb_gnt),
        .valid_o  (arb_valid)
    );

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        timer_d      = timer_q;
        mm_wr_en_d   = 1'b0;
        mm_rd_en_d   = 1'b0;
        mm_addr_d    = mm_addr_q;
        mm_wr_data_d = mm_wr_data_q;
        ack_d        = 2'b00;
        rd_v_d       = 2'b00;
        err_d        = 2'b00;
        rd_data_d[0] = rd_data_q[0];
        rd_data_d[1] = rd_data_q[1];
        cnt_d        = cnt_q;
        arb_update   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    arb_update   = 1'b1;
                    gnt_d        = arb_gnt;
                    mm_addr_d    = m_addr[arb_gnt];
                    mm_wr_data_d = m_data[arb_gnt];
                    // WR_EN takes precedence when a master raises both.
                    mm_wr_en_d   = m_wr[arb_gnt];
                    mm_rd_en_d   = ~m_wr[arb_gnt];
                    ack_d[arb_gnt] = m_wr[arb_gnt];
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                timer_d = '0;
                state_d = mm_wr_en_q ? IDLE : RD_WAIT;
            end
            RD_WAIT: begin
                timer_d = timer_q + 1'b1;
                if (iMM_RD_DATA_V) begin
                    rd_data_d[gnt_q] = iMM_RD_DATA;
                    ack_d[gnt_q]     = 1'b1;
                    rd_v_d[gnt_q]    = 1'b1;
                    state_d          = DONE;
                end else if (timer_q == TMR_MAX) begin
                    rd_data_d[gnt_q] = tmo_data;
                    ack_d[gnt_q]     = 1'b1;
                    rd_v_d[gnt_q]    = 1'b1;
                    err_d[gnt_q]     = 1'b1;
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (iTIMEOUT_CLR) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            gnt_q        <= 1'b0;
            timer_q      <= '0;
            mm_wr_en_q   <= 1'b0;
            mm_rd_en_q   <= 1'b0;
            mm_addr_q    <= '0;
            mm_wr_data_q <= '0;
            ack_q        <= 2'b00;
            rd_v_q       <= 2'b00;
            err_q        <= 2'b00;
            rd_data_q[0] <= '0;
            rd_data_q[1] <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            timer_q      <= timer_d;
            mm_wr_en_q   <= mm_wr_en_d;
            mm_rd_en_q   <= mm_rd_en_d;
            mm_addr_q    <= mm_addr_d;
            mm_wr_data_q <= mm_wr_data_d;
            ack_q        <= ack_d;
            rd_v_q       <= rd_v_d;
            err_q        <= err_d;
            rd_data_q[0] <= rd_data_d[0];
            rd_data_q[1] <= rd_data_d[1];
            cnt_q        <= cnt_d;
        end
    end

    assign oM0_ACK       = ack_q[0];
    assign oM1_ACK       = ack_q[1];
    assign oM0_RD_DATA_V = rd_v_q[0];
    assign oM1_RD_DATA_V = rd_v_q[1];
    assign oM0_ERR       = err_q[0];
    assign oM1_ERR       = err_q[1];
    assign oM0_RD_DATA   = rd_data_q[0];
    assign oM1_RD_DATA   = rd_data_q[1];
    assign oMM_WR_EN     = mm_wr_en_q;
    assign oMM_RD_EN     = mm_rd_en_q;
    assign oMM_ADDR      = mm_addr_q;
    assign oMM_WR_DATA   = mm_wr_data_q;
    assign oTIMEOUT_CNT  = cnt_q;

endmodule

// File: tb/tb_mm_bus_arbiter.sv
// Randomised self-checking bench for mm_bus_arbiter (TIMEOUT_CYC = 16, CNT_W = 4 build).
module tb_mm_bus_arbiter;

    localparam int T  = 16;
    localparam int CW = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        iM0_WR_EN, iM1_WR_EN, iM0_RD_EN, iM1_RD_EN;
    logic [16:0] iM0_ADDR, iM1_ADDR;
    logic [63:0] iM0_WR_DATA, iM1_WR_DATA;
    logic        oM0_ACK, oM1_ACK;
    logic [63:0] oM0_RD_DATA, oM1_RD_DATA;
    logic        oM0_RD_DATA_V, oM1_RD_DATA_V, oM0_ERR, oM1_ERR;
    logic        oMM_WR_EN, oMM_RD_EN;
    logic [16:0] oMM_ADDR;
    logic [63:0] oMM_WR_DATA;
    logic [63:0] iMM_RD_DATA;
    logic        iMM_RD_DATA_V;
    logic        iTIMEOUT_CLR;
    logic [CW-1:0] oTIMEOUT_CNT;

    // Reference state: who was granted last, what each master last read, timeout count.
    int          last_m;
    logic [63:0] exp_rd [2];
    int          exp_cnt;
    int          n_tests = 0;
    int          n_fail  = 0;

    mm_bus_arbiter #(
        .ADDR_W      (17),
        .DATA_W      (64),
        .TIMEOUT_CYC (T),
        .CNT_W       (CW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .iM0_WR_EN     (iM0_WR_EN),
        .iM1_WR_EN     (iM1_WR_EN),
        .iM0_RD_EN     (iM0_RD_EN),
        .iM1_RD_EN     (iM1_RD_EN),
        .iM0_ADDR      (iM0_ADDR),
        .iM1_ADDR      (iM1_ADDR),
        .iM0_WR_DATA   (iM0_WR_DATA),
        .iM1_WR_DATA   (iM1_WR_DATA),
        .oM0_ACK       (oM0_ACK),
        .oM1_ACK       (oM1_ACK),
        .oM0_RD_DATA   (oM0_RD_DATA),
        .oM1_RD_DATA   (oM1_RD_DATA),
        .oM0_RD_DATA_V (oM0_RD_DATA_V),
        .oM1_RD_DATA_V (oM1_RD_DATA_V),
        .oM0_ERR       (oM0_ERR),
        .oM1_ERR       (oM1_ERR),
        .oMM_WR_EN     (oMM_WR_EN),
        .oMM_RD_EN     (oMM_RD_EN),
        .oMM_ADDR      (oMM_ADDR),
        .oMM_WR_DATA   (oMM_WR_DATA),
        .iMM_RD_DATA   (iMM_RD_DATA),
        .iMM_RD_DATA_V (iMM_RD_DATA_V),
        .iTIMEOUT_CLR  (iTIMEOUT_CLR),
        .oTIMEOUT_CNT  (oTIMEOUT_CNT)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        last_m    = 1;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        exp_cnt   = 0;
    endtask

    task automatic drive(input int m, input bit wr, input bit rd, input logic [16:0] a,
                         input logic [63:0] d);
        if (m == 0) begin
            iM0_WR_EN = wr; iM0_RD_EN = rd; iM0_ADDR = a; iM0_WR_DATA = d;
        end else begin
            iM1_WR_EN = wr; iM1_RD_EN = rd; iM1_ADDR = a; iM1_WR_DATA = d;
        end
    endtask

    task automatic drop(input int m);
        if (m == 0) begin
            iM0_WR_EN = 1'b0; iM0_RD_EN = 1'b0;
        end else begin
            iM1_WR_EN = 1'b0; iM1_RD_EN = 1'b0;
        end
    endtask

    function automatic int pick(input bit r0, input bit r1);
        if (r0 && r1) return (last_m == 1) ? 0 : 1;
        return r0 ? 0 : 1;
    endfunction

    // Entered in an IDLE cycle with master m requesting; returns in the ACK cycle.
    // lat = RD_WAIT cycle carrying the slave's valid; lat >= T means no response.
    task automatic serve(input int m, input bit wr, input logic [16:0] a, input logic [63:0] d,
                         input int lat, input logic [63:0] rdat, input bit clr);
        int          kend;
        bit          tmo;
        logic [1:0]  oh;
        logic [63:0] exp;
        oh = 2'b01 << m;
        tick();
        n_tests++;
        if (oMM_WR_EN !== wr || oMM_RD_EN !== !wr || oMM_ADDR !== a || oMM_WR_DATA !== d) begin
            n_fail++;
            $display("FAIL issue m%0d: wr=%b rd=%b addr=%h data=%h, required wr=%b rd=%b addr=%h data=%h",
                     m, oMM_WR_EN, oMM_RD_EN, oMM_ADDR, oMM_WR_DATA, wr, !wr, a, d);
        end
        n_tests++;
        if ({oM1_ACK, oM0_ACK} !== (wr ? oh : 2'b00) || {oM1_RD_DATA_V, oM0_RD_DATA_V} !== 2'b00) begin
            n_fail++;
            $display("FAIL issue_ack m%0d: ack=%b rdv=%b, required ack=%b rdv=00",
                     m, {oM1_ACK, oM0_ACK}, {oM1_RD_DATA_V, oM0_RD_DATA_V}, wr ? oh : 2'b00);
        end
        last_m = m;
        if (wr) begin
            drop(m);
            return;
        end
        tmo  = (lat >= T);
        kend = tmo ? T - 1 : lat;
        for (int k = 0; k <= kend; k++) begin
            tick();
            n_tests++;
            if ({oMM_WR_EN, oMM_RD_EN, oM1_ACK, oM0_ACK, oM1_RD_DATA_V, oM0_RD_DATA_V} !== 6'b0) begin
                n_fail++;
                $display("FAIL wait m%0d k=%0d: strobes=%b acks=%b rdv=%b, required all 0", m, k,
                         {oMM_WR_EN, oMM_RD_EN}, {oM1_ACK, oM0_ACK}, {oM1_RD_DATA_V, oM0_RD_DATA_V});
            end
            if (k == kend) begin
                if (!tmo) begin
                    iMM_RD_DATA_V = 1'b1;
                    iMM_RD_DATA   = rdat;
                end
                if (clr) iTIMEOUT_CLR = 1'b1;
            end
        end
        tick();
        iMM_RD_DATA_V = 1'b0;
        iTIMEOUT_CLR  = 1'b0;
        iMM_RD_DATA   = {$urandom, $urandom};
        exp = tmo ? {32'hDEAD_0BAD, 15'd0, a} : rdat;
        exp_rd[m] = exp;
        if (tmo) exp_cnt = (exp_cnt == (1 << CW) - 1) ? exp_cnt : exp_cnt + 1;
        if (clr) exp_cnt = 0;
        n_tests++;
        if ({oM1_ACK, oM0_ACK} !== oh || {oM1_RD_DATA_V, oM0_RD_DATA_V} !== oh
            || {oM1_ERR, oM0_ERR} !== (tmo ? oh : 2'b00)) begin
            n_fail++;
            $display("FAIL done m%0d: ack=%b rdv=%b err=%b, required ack=%b rdv=%b err=%b", m,
                     {oM1_ACK, oM0_ACK}, {oM1_RD_DATA_V, oM0_RD_DATA_V}, {oM1_ERR, oM0_ERR},
                     oh, oh, tmo ? oh : 2'b00);
        end
        n_tests++;
        if (oM0_RD_DATA !== exp_rd[0] || oM1_RD_DATA !== exp_rd[1]) begin
            n_fail++;
            $display("FAIL rd_data m%0d: m0=%h m1=%h, required m0=%h m1=%h", m,
                     oM0_RD_DATA, oM1_RD_DATA, exp_rd[0], exp_rd[1]);
        end
        n_tests++;
        if (oTIMEOUT_CNT !== CW'(exp_cnt)) begin
            n_fail++;
            $display("FAIL timeout_cnt m%0d: got %0d, required %0d", m, oTIMEOUT_CNT, exp_cnt);
        end
        drop(m);
    endtask

    task automatic apply_reset(input int cycles);
        rst_n = 1'b0;
        for (int i = 0; i < cycles; i++) tick();
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        drive(0, 1'b1, 1'b0, 17'h1, 64'h1);
        drive(1, 1'b0, 1'b1, 17'h2, 64'h2);
        rst_n = 1'b0;
        tick();
        tick();
        n_tests++;
        if ({oM0_ACK, oM1_ACK, oM0_RD_DATA, oM1_RD_DATA, oM0_RD_DATA_V, oM1_RD_DATA_V, oM0_ERR,
             oM1_ERR, oMM_WR_EN, oMM_RD_EN, oMM_ADDR, oMM_WR_DATA, oTIMEOUT_CNT} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: strobes=%b acks=%b addr=%h cnt=%0d, required all 0",
                     {oMM_WR_EN, oMM_RD_EN}, {oM1_ACK, oM0_ACK}, oMM_ADDR, oTIMEOUT_CNT);
        end
        drop(0);
        drop(1);
        rst_n = 1'b1;
        model_reset();
        tick();
    endtask

    task automatic test_write_single();
        drive(0, 1'b1, 1'b0, 17'h04010, 64'h1122_3344_5566_7788);
        serve(0, 1'b1, 17'h04010, 64'h1122_3344_5566_7788, 0, '0, 1'b0);
        tick();
        n_tests++;
        if ({oMM_WR_EN, oMM_RD_EN, oM1_ACK, oM0_ACK} !== 4'b0 || oMM_ADDR !== 17'h04010) begin
            n_fail++;
            $display("FAIL write_after: strobes=%b acks=%b addr=%h, required 0/0/04010",
                     {oMM_WR_EN, oMM_RD_EN}, {oM1_ACK, oM0_ACK}, oMM_ADDR);
        end
    endtask

    task automatic test_contention();
        int first;
        apply_reset(1);
        drive(0, 1'b0, 1'b1, 17'h00100, 64'h0);
        drive(1, 1'b0, 1'b1, 17'h00200, 64'h0);
        first = pick(1'b1, 1'b1);
        serve(first, 1'b0, first == 0 ? 17'h00100 : 17'h00200, 64'h0, 2,
              first == 0 ? 64'hA5 : 64'h5A, 1'b0);
        tick();
        serve(1 - first, 1'b0, first == 0 ? 17'h00200 : 17'h00100, 64'h0, 2,
              first == 0 ? 64'h5A : 64'hA5, 1'b0);
        tick();
        drive(0, 1'b1, 1'b0, 17'h00300, 64'h33);
        drive(1, 1'b1, 1'b0, 17'h00400, 64'h44);
        first = pick(1'b1, 1'b1);
        serve(first, 1'b1, first == 0 ? 17'h00300 : 17'h00400, first == 0 ? 64'h33 : 64'h44,
              0, '0, 1'b0);
        tick();
        serve(1 - first, 1'b1, first == 0 ? 17'h00400 : 17'h00300, first == 0 ? 64'h44 : 64'h33,
              0, '0, 1'b0);
        tick();
    endtask

    task automatic test_timeout();
        int cnt_before;
        drive(1, 1'b0, 1'b1, 17'h1_2345, 64'h0);
        serve(1, 1'b0, 17'h1_2345, 64'h0, T + 10, '0, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        cnt_before    = exp_cnt;
        iMM_RD_DATA   = 64'hBAD_BAD;
        iMM_RD_DATA_V = 1'b1;
        tick();
        iMM_RD_DATA_V = 1'b0;
        tick();
        n_tests++;
        if ({oM1_ACK, oM0_ACK, oM1_RD_DATA_V, oM0_RD_DATA_V, oM1_ERR, oM0_ERR} !== 6'b0
            || oM1_RD_DATA !== exp_rd[1] || oTIMEOUT_CNT !== CW'(cnt_before)) begin
            n_fail++;
            $display("FAIL late_valid: acks=%b m1data=%h cnt=%0d, required acks=00 m1data=%h cnt=%0d",
                     {oM1_ACK, oM0_ACK}, oM1_RD_DATA, oTIMEOUT_CNT, exp_rd[1], cnt_before);
        end
        drive(0, 1'b0, 1'b1, 17'h0_0077, 64'h0);
        serve(0, 1'b0, 17'h0_0077, 64'h0, T - 1, 64'h77, 1'b0);
        tick();
    endtask

    task automatic test_reset_midread();
        drive(1, 1'b0, 1'b1, 17'h0_0ABC, 64'h0);
        tick();
        for (int i = 0; i < 3; i++) tick();
        rst_n = 1'b0;
        tick();
        n_tests++;
        if ({oM0_ACK, oM1_ACK, oM0_RD_DATA, oM1_RD_DATA, oM0_RD_DATA_V, oM1_RD_DATA_V, oM0_ERR,
             oM1_ERR, oMM_WR_EN, oMM_RD_EN, oMM_ADDR, oMM_WR_DATA, oTIMEOUT_CNT} !== '0) begin
            n_fail++;
            $display("FAIL midread_reset: acks=%b strobes=%b addr=%h cnt=%0d, required all 0",
                     {oM1_ACK, oM0_ACK}, {oMM_WR_EN, oMM_RD_EN}, oMM_ADDR, oTIMEOUT_CNT);
        end
        rst_n = 1'b1;
        model_reset();
        serve(1, 1'b0, 17'h0_0ABC, 64'h0, $urandom_range(0, T - 1), 64'hC0FFEE, 1'b0);
        tick();
    endtask

    task automatic test_saturate();
        int m;
        logic [16:0] a;
        for (int i = 0; i < (1 << CW) + 2; i++) begin
            m = $urandom_range(0, 1);
            a = 17'($urandom);
            drive(m, 1'b0, 1'b1, a, 64'h0);
            serve(m, 1'b0, a, 64'h0, T + $urandom_range(0, 3), '0, 1'b0);
            tick();
        end
        drive(0, 1'b0, 1'b1, 17'h0_0FFF, 64'h0);
        serve(0, 1'b0, 17'h0_0FFF, 64'h0, T, '0, 1'b1);
        tick();
    endtask

    task automatic test_random();
        int t0, t1, first, lat0, lat1;
        logic [16:0] a0, a1;
        logic [63:0] d0, d1, r0, r1;
        for (int it = 0; it < 40; it++) begin
            t0 = $urandom_range(0, 3);
            t1 = $urandom_range(0, 3);
            if (t0 == 0 && t1 == 0) t0 = 2;
            a0 = 17'($urandom); a1 = 17'($urandom);
            d0 = {$urandom, $urandom}; d1 = {$urandom, $urandom};
            r0 = {$urandom, $urandom}; r1 = {$urandom, $urandom};
            lat0 = $urandom_range(0, T + 3);
            lat1 = $urandom_range(0, T + 3);
            drive(0, t0 == 1 || t0 == 3, t0 >= 2, a0, d0);
            drive(1, t1 == 1 || t1 == 3, t1 >= 2, a1, d1);
            first = pick(t0 != 0, t1 != 0);
            if (first == 0) serve(0, t0 == 1 || t0 == 3, a0, d0, lat0, r0, $urandom_range(0, 7) == 0);
            else            serve(1, t1 == 1 || t1 == 3, a1, d1, lat1, r1, $urandom_range(0, 7) == 0);
            tick();
            if (first == 0 && t1 != 0) begin
                serve(1, t1 == 1 || t1 == 3, a1, d1, lat1, r1, 1'b0);
                tick();
            end else if (first == 1 && t0 != 0) begin
                serve(0, t0 == 1 || t0 == 3, a0, d0, lat0, r0, 1'b0);
                tick();
            end
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        iM0_WR_EN     = 1'b0; iM1_WR_EN = 1'b0; iM0_RD_EN = 1'b0; iM1_RD_EN = 1'b0;
        iM0_ADDR      = '0;   iM1_ADDR  = '0;   iM0_WR_DATA = '0; iM1_WR_DATA = '0;
        iMM_RD_DATA   = '0;
        iMM_RD_DATA_V = 1'b0;
        iTIMEOUT_CLR  = 1'b0;
        model_reset();
        #1;
        test_reset();
        test_contention();
        test_write_single();
        test_timeout();
        test_reset_midread();
        test_saturate();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
